// File: rtl/fdiv_iter.sv
// fdiv_iter: iterative IEEE-754 single divider, restoring division one bit per cycle; define FDIV_ROUND_EN for round-to-nearest-even
module fdiv_iter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         dz
);
  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
  state_t state;
  logic sign;
  logic signed [9:0] exp_d;
  logic [23:0] mb;
  logic [25:0] rem, rem_sel, q;
  logic [4:0] cnt;
  logic [7:0] ea, eb;
  logic s_in, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, nan_case, spec_hit, spec_dz;
  logic [N-1:0] spec_val, result;
  logic ge, msb, carry;
  logic [23:0] mant;
  logic [24:0] mant_r;
  logic rnd;
  logic signed [9:0] e_n, e_f;
  assign ea = a[30:23];
  assign eb = b[30:23];
  assign s_in = a[31] ^ b[31];
  assign a_zero = ea == 8'd0;
  assign b_zero = eb == 8'd0;
  assign a_inf = ea == 8'hFF && a[22:0] == 23'd0;
  assign b_inf = eb == 8'hFF && b[22:0] == 23'd0;
  assign a_nan = ea == 8'hFF && a[22:0] != 23'd0;
  assign b_nan = eb == 8'hFF && b[22:0] != 23'd0;
  assign nan_case = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
  assign spec_hit = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
  assign spec_dz = b_zero & ~a_zero & ~a_inf & ~nan_case;
  assign spec_val = nan_case ? 32'h7FC00000 : (a_inf | b_zero) ? {s_in, 8'hFF, 23'd0} : {s_in, 31'd0};
  assign ge = rem >= {2'b00, mb};
  assign rem_sel = ge ? rem - {2'b00, mb} : rem;
  // quotient lies in (0.5, 2): q[25] is the integer bit when the dividend significand is the larger
  assign msb = q[25];
  assign mant = msb ? q[25:2] : q[24:1];
  assign e_n = msb ? exp_d : exp_d - 10'sd1;
`ifdef FDIV_ROUND_EN
  logic guard, sticky;
  assign guard = msb ? q[1] : q[0];
  assign sticky = (msb & q[0]) | (|rem);
  assign rnd = guard & (sticky | mant[0]);
`else
  assign rnd = 1'b0;
`endif
  assign mant_r = {1'b0, mant} + {24'd0, rnd};
  assign carry = mant_r[24];
  assign e_f = e_n + 10'(carry);
  assign result = e_f >= 10'sd255 ? {sign, 8'hFF, 23'd0} :
                  e_f <= 10'sd0   ? {sign, 31'd0} :
                  {sign, e_f[7:0], carry ? 23'd0 : mant_r[22:0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      out <= '0;
      dz <= 1'b0;
      sign <= 1'b0;
      exp_d <= '0;
      mb <= '0;
      rem <= '0;
      q <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign <= s_in;
          exp_d <= 10'(ea) - 10'(eb) + 10'sd127;
          mb <= {1'b1, b[22:0]};
          rem <= {3'b001, a[22:0]};
          q <= '0;
          cnt <= '0;
          in_ready <= 1'b0;
          if (spec_hit) begin
            out <= spec_val;
            dz <= spec_dz;
            out_valid <= 1'b1;
            state <= DONE;
          end else begin
            state <= DIV;
          end
        end
        DIV: begin
          rem <= rem_sel << 1;
          q <= {q[24:0], ge};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd25) state <= NORM;
        end
        NORM: begin
          out <= result;
          dz <= 1'b0;
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fdiv_iter.sv
// tb_fdiv_iter: vector table, handshake corner sequences and random ops against an arithmetic reference model
module tb_fdiv_iter;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, dz;
  logic [31:0] a, b, out;
  int checks = 0;
  int fails = 0;

  fdiv_iter #(.N(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .dz(dz)
  );

  always #5 clk = ~clk;

`ifdef FDIV_ROUND_EN
  localparam logic [31:0] one_third = 32'h3EAAAAAB;
`else
  localparam logic [31:0] one_third = 32'h3EAAAAAA;
`endif

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] o;
    logic        d;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // quotient from wide integer division, then normalise, round and range-check
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic d, output int lat);
    logic [7:0] ex, ey;
    logic s, xz, yz, xi, yi, xn, yn;
    longint ma, mb, num, qq, rr, mant, low, half;
    int e, sh;
    ex = x[30:23];
    ey = y[30:23];
    s = x[31] ^ y[31];
    xz = ex == 0;
    yz = ey == 0;
    xi = ex == 255 && x[22:0] == 0;
    yi = ey == 255 && y[22:0] == 0;
    xn = ex == 255 && x[22:0] != 0;
    yn = ey == 255 && y[22:0] != 0;
    d = 1'b0;
    lat = 1;
    r = '0;
    if (xn || yn || (xz && yz) || (xi && yi)) r = 32'h7FC00000;
    else if (xi) r = {s, 8'hFF, 23'h0};
    else if (yz) begin
      r = {s, 8'hFF, 23'h0};
      d = 1'b1;
    end else if (xz || yi) r = {s, 31'h0};
    else begin
      lat = 28;
      ma = longint'({1'b1, x[22:0]});
      mb = longint'({1'b1, y[22:0]});
      num = ma << 30;
      qq = num / mb;
      rr = num % mb;
      e = int'(ex) - int'(ey) + 127;
      sh = 7;
      if (qq < (longint'(1) << 30)) begin
        sh = 6;
        e--;
      end
      mant = qq >> sh;
      low = qq & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
`ifdef FDIV_ROUND_EN
      if (low > half || (low == half && (rr != 0 || mant[0]))) mant++;
      if (mant == (longint'(1) << 24)) begin
        mant = longint'(1) << 23;
        e++;
      end
`endif
      if (e >= 255) r = {s, 8'hFF, 23'h0};
      else if (e <= 0) r = {s, 31'h0};
      else r = {s, 8'(e), mant[22:0]};
    end
  endfunction

  task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_o, input logic exp_d, input int exp_lat);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b1;
    a = x;
    b = y;
    @(posedge clk); #1;
    in_valid = 1'($urandom_range(0, 1));
    a = $urandom;
    b = $urandom;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk({name, " out"}, 64'(out), 64'(exp_o));
    chk({name, " dz"}, 64'(dz), 64'(exp_d));
    chk({name, " latency"}, 64'(cyc), 64'(exp_lat));
    @(posedge clk); #1;
    chk({name, " release"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 15);
    if (k == 0) v[30:23] = 8'd0;
    else if (k == 1) begin
      v[30:23] = 8'hFF;
      if ($urandom_range(0, 1) == 0) v[22:0] = '0;
    end else if (k <= 3) v[30:23] = 8'($urandom_range(1, 254));
    else v[30:23] = 8'(87 + $urandom_range(0, 80));
    return v;
  endfunction

  initial begin
    vec_t vt[12];
    logic [31:0] x, y, ro;
    logic rd;
    int rl, cyc;
    vt[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28};
    vt[1]  = '{32'h3F800000, 32'h40400000, one_third,    1'b0, 28};
    vt[2]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1};
    vt[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1};
    vt[4]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 28};
    vt[5]  = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 28};
    vt[6]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1};
    vt[7]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1};
    vt[8]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0, 1};
    vt[9]  = '{32'h40000000, 32'hFF800000, 32'h80000000, 1'b0, 1};
    vt[10] = '{32'h80000000, 32'hC0400000, 32'h00000000, 1'b0, 1};
    vt[11] = '{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1};
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset state", {29'd0, out, in_ready, out_valid, dz}, {29'd0, 32'd0, 3'b100});
    for (int i = 0; i < 12; i++) run_op($sformatf("vec%0d", i), vt[i].x, vt[i].y, vt[i].o, vt[i].d, vt[i].lat);
    // result held under back-pressure
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 32'h40C00000;
    b = 32'h40000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("hold latency", 64'(cyc), 64'd28);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold cycle %0d", i), {out, 29'd0, dz, out_valid, in_ready}, {32'h40400000, 29'd0, 3'b010});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold release", {62'd0, out_valid, in_ready}, 64'd1);
    // reset in the middle of division
    in_valid = 1'b1;
    a = 32'h40C00000;
    b = 32'h40000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort state", {29'd0, out, in_ready, out_valid, dz}, {29'd0, 32'd0, 3'b100});
    repeat (30) @(posedge clk);
    #1;
    chk("abort no result", 64'(out_valid), 64'd0);
    run_op("after abort", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28);
    for (int i = 0; i < 200; i++) begin
      x = rnd_operand();
      y = rnd_operand();
      ref_div(x, y, ro, rd, rl);
      run_op($sformatf("rand%0d %h/%h", i, x, y), x, y, ro, rd, rl);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
